// File: rtl/port_tx.sv
// Node port write: captures one word and offers it to L/R/U/D, ANY or LAST neighbour.
// Latency: offer visible the cycle after send_req; earliest ack/done in that same offer cycle.
// Backpressure: holds the offer and stalls the core until a neighbour is ready; NIL writes complete at once.
module port_tx #(
    parameter int WORD_W = 11
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              send_req,
    input  logic [2:0]        send_dir,
    input  logic [WORD_W-1:0] send_data,
    output logic              stall,
    output logic              done,
    output logic [3:0]        out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic [3:0]        out_ready,
    output logic [3:0]        out_ack,
    output logic              last_valid,
    output logic [1:0]        last_dir
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  mask;
    logic        is_any;

    logic        cap;
    logic [3:0]  cap_mask;
    logic        cap_any;
    logic        hit;
    logic [1:0]  win_idx;
    logic        upd_last;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        out_ack   = 4'b0000;
        out_valid = 4'b0000;
        cap       = 1'b0;
        cap_mask  = 4'b0000;
        cap_any   = 1'b0;
        hit       = 1'b0;
        win_idx   = 2'd0;
        upd_last  = 1'b0;

        case (state)
            IDLE: begin
                if (send_req) begin
                    case (send_dir)
                        3'd0, 3'd1, 3'd2, 3'd3: cap_mask = 4'b0001 << send_dir[1:0];
                        3'd4: begin
                            cap_mask = 4'b1111;
                            cap_any  = 1'b1;
                        end
                        3'd5: if (last_valid) cap_mask = 4'b0001 << last_dir;
                        default: cap_mask = 4'b0000;
                    endcase
                    // An empty mask means NIL (or LAST with nothing recorded): drop the word.
                    if (cap_mask != 4'b0000) begin
                        cap       = 1'b1;
                        stall     = 1'b1;
                        state_nxt = OFFER;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            OFFER: begin
                out_valid = mask;
                // Scan high to low so the lowest ready index wins.
                for (int i = 3; i >= 0; i--) begin
                    if (mask[i] && out_ready[i]) begin
                        hit     = 1'b1;
                        win_idx = 2'(i);
                    end
                end
                if (hit) begin
                    out_ack   = 4'b0001 << win_idx;
                    done      = 1'b1;
                    upd_last  = is_any;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            out_data   <= '0;
            mask       <= 4'b0000;
            is_any     <= 1'b0;
            last_valid <= 1'b0;
            last_dir   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                out_data <= send_data;
                mask     <= cap_mask;
                is_any   <= cap_any;
            end
            if (upd_last) begin
                last_valid <= 1'b1;
                last_dir   <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_port_tx.sv
// Directed bench for port_tx: inputs change 1 unit after the rising edge, outputs are checked 1 unit later.
module tb_port_tx;

    localparam int WORD_W = 11;

    logic              clk;
    logic              nrst;
    logic              send_req;
    logic [2:0]        send_dir;
    logic [WORD_W-1:0] send_data;
    logic              stall;
    logic              done;
    logic [3:0]        out_valid;
    logic [WORD_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [3:0]        out_ack;
    logic              last_valid;
    logic [1:0]        last_dir;

    int total = 0;
    int bad   = 0;

    port_tx #(.WORD_W(WORD_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .send_req   (send_req),
        .send_dir   (send_dir),
        .send_data  (send_data),
        .stall      (stall),
        .done       (done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_ack    (out_ack),
        .last_valid (last_valid),
        .last_dir   (last_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [2:0] dir, input logic [WORD_W-1:0] dat,
                         input logic [3:0] rdy);
        send_req  = req;
        send_dir  = dir;
        send_data = dat;
        out_ready = rdy;
        #1;
    endtask

    initial begin
        nrst      = 1'b0;
        send_req  = 1'b0;
        send_dir  = 3'd0;
        send_data = '0;
        out_ready = 4'b0000;
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ack", 32'(out_ack), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_last", {29'd0, last_valid, last_dir}, 32'h0);
        nrst = 1'b1;

        // LAST before any ANY transfer behaves as NIL, then explicit NIL.
        cyc();
        drive(1'b1, 3'd5, 11'd5, 4'b0000);
        chk("last_nil_done", 32'(done), 32'h1);
        chk("last_nil_stall", 32'(stall), 32'h0);
        cyc();
        drive(1'b1, 3'd6, 11'd6, 4'b0000);
        chk("last_nil_valid", 32'(out_valid), 32'h0);
        chk("nil_done", 32'(done), 32'h1);
        chk("nil_stall", 32'(stall), 32'h0);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0000);
        chk("nil_valid", 32'(out_valid), 32'h0);
        chk("nil_data", 32'(out_data), 32'h0);

        // Directed RIGHT with three waiting cycles.
        cyc();
        drive(1'b1, 3'd1, 11'd42, 4'b0000);
        chk("dir_req_stall", 32'(stall), 32'h1);
        chk("dir_req_done", 32'(done), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive(1'b0, 3'd0, 11'd0, 4'b0000);
            chk("dir_wait_valid", 32'(out_valid), 32'h2);
            chk("dir_wait_stall", 32'(stall), 32'h1);
            chk("dir_wait_ack", 32'(out_ack), 32'h0);
        end
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0010);
        chk("dir_ack", 32'(out_ack), 32'h2);
        chk("dir_done", 32'(done), 32'h1);
        chk("dir_stall", 32'(stall), 32'h0);
        chk("dir_data", 32'(out_data), 32'd42);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0000);
        chk("dir_after_valid", 32'(out_valid), 32'h0);
        chk("dir_last_valid", 32'(last_valid), 32'h0);

        // ANY with UP and DOWN ready: UP wins.
        drive(1'b1, 3'd4, 11'h419, 4'b0000);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b1100);
        chk("any_valid", 32'(out_valid), 32'hf);
        chk("any_ack", 32'(out_ack), 32'h4);
        chk("any_done", 32'(done), 32'h1);
        chk("any_data", 32'(out_data), 32'h419);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0000);
        chk("any_last_valid", 32'(last_valid), 32'h1);
        chk("any_last_dir", 32'(last_dir), 32'h2);

        // LAST now targets UP only.
        drive(1'b1, 3'd5, 11'd7, 4'b1111);
        chk("last_req_stall", 32'(stall), 32'h1);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b1111);
        chk("last_valid_mask", 32'(out_valid), 32'h4);
        chk("last_ack", 32'(out_ack), 32'h4);
        chk("last_data", 32'(out_data), 32'd7);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0000);
        chk("last_dir_kept", 32'(last_dir), 32'h2);

        // Reset while offering LEFT.
        drive(1'b1, 3'd0, 11'd123, 4'b0000);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0000);
        chk("rmid_valid_pre", 32'(out_valid), 32'h1);
        nrst = 1'b0;
        #1;
        chk("rmid_valid", 32'(out_valid), 32'h0);
        chk("rmid_ack", 32'(out_ack), 32'h0);
        chk("rmid_done", 32'(done), 32'h0);
        chk("rmid_last", 32'(last_valid), 32'h0);
        out_ready = 4'b0001;
        cyc();
        chk("rmid_hold_done", 32'(done), 32'h0);
        nrst = 1'b1;
        cyc();
        drive(1'b1, 3'd0, 11'd9, 4'b0001);
        chk("rpost_stall", 32'(stall), 32'h1);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b0001);
        chk("rpost_ack", 32'(out_ack), 32'h1);
        chk("rpost_data", 32'(out_data), 32'd9);
        chk("rpost_done", 32'(done), 32'h1);

        // Back-to-back DOWN writes with DOWN always ready; the second request
        // is also presented during the first offer and must be ignored there.
        cyc();
        drive(1'b1, 3'd3, 11'd100, 4'b1000);
        chk("b2b_req1_stall", 32'(stall), 32'h1);
        cyc();
        drive(1'b1, 3'd3, 11'd200, 4'b1000);
        chk("b2b_ack1", 32'(out_ack), 32'h8);
        chk("b2b_done1", 32'(done), 32'h1);
        chk("b2b_data1", 32'(out_data), 32'd100);
        cyc();
        drive(1'b1, 3'd3, 11'd200, 4'b1000);
        chk("b2b_gap_ack", 32'(out_ack), 32'h0);
        chk("b2b_gap_done", 32'(done), 32'h0);
        chk("b2b_gap_stall", 32'(stall), 32'h1);
        cyc();
        drive(1'b0, 3'd0, 11'd0, 4'b1000);
        chk("b2b_ack2", 32'(out_ack), 32'h8);
        chk("b2b_done2", 32'(done), 32'h1);
        chk("b2b_data2", 32'(out_data), 32'd200);
        cyc();
        chk("b2b_idle_done", 32'(done), 32'h0);
        chk("b2b_idle_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
